pcie_tl_tx_mvc: RTL and testbench
=================================

# pcie_tl_tx_mvc

Parametrised multi-virtual-channel TLP transmit scheduler for the PCIe transaction layer TX path. It accepts pre-built TLPs (header + one data beat) on a valid/ready request port and maps each Traffic Class to one of `NUM_VC` virtual channels. Each VC is buffered in its own FIFO, gated by per-VC header flow-control credits, and arbitrated round-robin into a registered TLP output toward the data-link layer. It supersedes the fixed two-VC, parity-routed, creditless TX path.

## Interface
Parameters:
- `NUM_VC`, 2: number of virtual channels, 1..8.
- `HDR_W`, 96: TLP header width.
- `DATA_W`, 128: TLP payload beat width.
- `FIFO_DEPTH`, 16: entries per VC FIFO, power of two, ≥2.
- `CRD_W`, 8: credit counter width.
- `INIT_CRD`, 16: per-VC credit value after reset, < 2^CRD_W.
- Derived `VC_W` = max(1, $clog2(NUM_VC)).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `tc2vc_map_i` in 8*VC_W: slice [tc*VC_W +: VC_W] is the VC for TC `tc`; quasi-static.
- `req_valid_i` in 1: request TLP valid.
- `req_ready_o` out 1: request accepted when valid & ready.
- `req_tc_i` in 3: TLP traffic class.
- `req_hdr_i` in HDR_W: TLP header.
- `req_data_i` in DATA_W: TLP payload (zero for reads).
- `crd_ret_valid_i` in 1: credit return strobe.
- `crd_ret_vc_i` in VC_W: VC receiving returned credits.
- `crd_ret_cnt_i` in CRD_W: credits returned.
- `tlp_valid_o` out 1: output TLP valid.
- `tlp_o` out HDR_W+DATA_W: {hdr, data}.
- `tlp_vc_o` out VC_W: VC of the output TLP.
- `tlp_ready_i` in 1: downstream accepts the output TLP.
- `vc_empty_o` out NUM_VC: per-VC FIFO empty.
- `vc_full_o` out NUM_VC: per-VC FIFO full.

## Operation
- Target VC: `tvc` = map[req_tc_i]. A `tvc` ≥ NUM_VC routes to VC0.
- `req_ready_o` = rst_n & !full[tvc], combinational. A full FIFO refuses pushes even in a same-cycle pop.
- Accept pushes {hdr, data} into FIFO[tvc].
- Eligible[v] = !empty[v] & credit[v] ≠ 0.
- Output slot is a single register. It loads when (!tlp_valid_o | tlp_ready_i) and some VC is eligible.
- Winner: the first eligible VC searching upward from rr_ptr, wrapping modulo NUM_VC.
- On load:
  - pop the winning FIFO;
  - decrement credit[winner];
  - set rr_ptr = winner+1 (mod NUM_VC);
  - register {data, vc}.
- If nothing is eligible when the slot frees, `tlp_valid_o` drops to 0.
- Credit update per VC: credit = min(credit − consumed + returned, 2^CRD_W−1), where consumed ∈ {0,1}. Same-cycle consume and return on one VC are combined in a single update.
- Credit return naming VC ≥ NUM_VC is ignored.
- Zero-credit VC: its FIFO keeps accepting until full; it is skipped by arbitration without moving rr_ptr.

## Timing
- Reset (synchronous, rst_n low at edge):
  - FIFO pointers cleared; vc_empty_o all 1, vc_full_o all 0;
  - credits = INIT_CRD; rr_ptr = 0;
  - tlp_valid_o = 0, tlp_o = 0, tlp_vc_o = 0;
  - req_ready_o = 0 while rst_n low.
- Reset mid-operation discards all queued TLPs and any held output.
- Latency: request accepted at edge E0 → tlp_valid_o high after E1 (2 cycles), given credit and an idle slot.
- Throughput: one TLP per cycle with tlp_ready_i held high and eligible traffic present.
- Output stability: while tlp_valid_o & !tlp_ready_i, tlp_o and tlp_vc_o hold.
- Returned credits are usable in the cycle after the return edge.
- vc_empty_o and vc_full_o are registered-pointer derived; they reflect pushes/pops after the edge.

## Structure
- Shared package (PCIe_PKG):
  - `VC_MAX` = 8;
  - TLP header struct and width constant;
  - `tlp_vc_t` typedef.
- Sub-module `tl_vc_sync_fifo`:
  - parametrised width/depth, show-ahead read (rd_data = mem[rd_ptr]);
  - synchronous active-low reset;
  - ptr-width+1 full/empty detection;
  - instantiated NUM_VC times via generate.
- Credit counters, round-robin arbiter and output register stay in the top.

## Test plan
- Reset, then TC0 TLP (hdr=0xA5.., data=0x1) with map TC0→VC0 → tlp_valid_o two cycles after accept, tlp_vc_o=0, credit[0] drops to 15.
- NUM_VC=4, map TCn→n%4, eight back-to-back TLPs TC0..7 with ready held low, then ready high → output VC order 0,1,2,3,0,1,2,3.
- INIT_CRD=2, three VC1 TLPs → two emitted, third held; crd_ret(vc=1,cnt=1) → third emitted the cycle after return.
- Fill VC0 with 16 TLPs, tlp_ready_i=0 → vc_full_o[0]=1, req_ready_o=0 for TC→VC0 while a TC→VC1 request is still accepted.
- tlp_ready_i toggled 0/1 every cycle → tlp_o stable whenever valid & !ready; no TLP dropped or duplicated.
- Credit at 254, return cnt=5 with simultaneous consume → credit saturates at 255. Reset asserted with 3 queued TLPs → all outputs return to reset values next edge.

Source files
------------

// File: rtl/pcie_tl_tx_mvc_pkg.sv
// Shared PCIe transaction-layer TX types and constants.
// Imported by the multi-VC scheduler and its per-VC FIFO.
package PCIe_PKG;

   localparam int VC_MAX = 8;

   typedef struct packed {
      logic [31:0] dw0;
      logic [31:0] dw1;
      logic [31:0] dw2;
   } tlp_hdr_t;

   localparam int TLP_HDR_W = $bits(tlp_hdr_t);

   typedef logic [$clog2(VC_MAX)-1:0] tlp_vc_t;

endpackage

// File: rtl/tl_vc_sync_fifo.sv
// Show-ahead synchronous FIFO holding queued TLPs for one virtual channel.
// The head entry is always visible on rd_data_o.
module tl_vc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]];
   assign empty_o   = (r_wr_ptr == r_rd_ptr);
   // Extra pointer bit distinguishes a full wrap from empty.
   assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pcie_tl_tx_mvc.sv
// Multi-VC TLP transmit scheduler: TC->VC mapping, per-VC FIFOs and header
// credits, round-robin arbitration into a single registered output slot.
module pcie_tl_tx_mvc
   import PCIe_PKG::*;
#(
   parameter int NUM_VC     = 2,
   parameter int HDR_W      = TLP_HDR_W,
   parameter int DATA_W     = 128,
   parameter int FIFO_DEPTH = 16,
   parameter int CRD_W      = 8,
   parameter int INIT_CRD   = 16,
   parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*VC_W-1:0]       tc2vc_map_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [2:0]              req_tc_i,
   input  logic [HDR_W-1:0]        req_hdr_i,
   input  logic [DATA_W-1:0]       req_data_i,
   input  logic                    crd_ret_valid_i,
   input  logic [VC_W-1:0]         crd_ret_vc_i,
   input  logic [CRD_W-1:0]        crd_ret_cnt_i,
   output logic                    tlp_valid_o,
   output logic [HDR_W+DATA_W-1:0] tlp_o,
   output logic [VC_W-1:0]         tlp_vc_o,
   input  logic                    tlp_ready_i,
   output logic [NUM_VC-1:0]       vc_empty_o,
   output logic [NUM_VC-1:0]       vc_full_o
);

   localparam int TLP_W = HDR_W + DATA_W;

   logic [VC_W-1:0]   w_map [8];
   logic [VC_W-1:0]   w_tvc;
   logic [NUM_VC-1:0] w_empty;
   logic [NUM_VC-1:0] w_full;
   logic [NUM_VC-1:0] w_push;
   logic [NUM_VC-1:0] w_pop;
   logic [NUM_VC-1:0] w_elig;
   logic [TLP_W-1:0]  w_rd_data [NUM_VC];
   logic [VC_W-1:0]   w_win;
   logic [VC_W-1:0]   w_win_next;
   logic              w_any;
   logic              w_slot_free;
   logic              w_load;
   logic [VC_W-1:0]   r_rr_ptr;
   logic              r_tlp_valid;
   logic [TLP_W-1:0]  r_tlp;
   logic [VC_W-1:0]   r_tlp_vc;

   genvar gi;

   for (gi = 0; gi < 8; gi++) begin : g_map
      assign w_map[gi] = tc2vc_map_i[gi*VC_W +: VC_W];
   end

   // Map entries naming a non-existent VC fall back to VC0.
   assign w_tvc       = (32'(w_map[req_tc_i]) < NUM_VC) ? w_map[req_tc_i] : '0;
   assign req_ready_o = rst_n & ~w_full[w_tvc];

   for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic [CRD_W-1:0] r_credit;
      logic [CRD_W-1:0] w_ret;
      logic [CRD_W:0]   w_crd_sum;

      assign w_push[gi] = req_valid_i & req_ready_o & (w_tvc == VC_W'(gi));
      assign w_pop[gi]  = w_load & (w_win == VC_W'(gi));
      assign w_elig[gi] = ~w_empty[gi] & (r_credit != '0);
      assign w_ret      = (crd_ret_valid_i && (crd_ret_vc_i == VC_W'(gi))) ? crd_ret_cnt_i : '0;
      // One spare bit catches overflow; consume never underflows since it needs credit.
      assign w_crd_sum  = {1'b0, r_credit} - {{CRD_W{1'b0}}, w_pop[gi]} + {1'b0, w_ret};

      always_ff @(posedge clk) begin
         if (!rst_n) r_credit <= CRD_W'(INIT_CRD);
         else        r_credit <= w_crd_sum[CRD_W] ? '1 : w_crd_sum[CRD_W-1:0];
      end

      tl_vc_sync_fifo #(
         .WIDTH (TLP_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push_i    (w_push[gi]),
         .wr_data_i ({req_hdr_i, req_data_i}),
         .pop_i     (w_pop[gi]),
         .rd_data_o (w_rd_data[gi]),
         .empty_o   (w_empty[gi]),
         .full_o    (w_full[gi])
      );
   end

   // Descending scan so the last hit is the nearest eligible VC at/after rr_ptr.
   always_comb begin
      int idx;
      idx   = 0;
      w_win = '0;
      w_any = 1'b0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         idx = int'(r_rr_ptr) + i;
         if (idx >= NUM_VC) idx = idx - NUM_VC;
         if (w_elig[idx]) begin
            w_win = VC_W'(idx);
            w_any = 1'b1;
         end
      end
   end

   assign w_win_next  = (32'(w_win) == NUM_VC - 1) ? '0 : w_win + 1'b1;
   assign w_slot_free = ~r_tlp_valid | tlp_ready_i;
   assign w_load      = w_slot_free & w_any;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tlp_valid <= 1'b0;
         r_tlp       <= '0;
         r_tlp_vc    <= '0;
         r_rr_ptr    <= '0;
      end else if (w_load) begin
         r_tlp_valid <= 1'b1;
         r_tlp       <= w_rd_data[w_win];
         r_tlp_vc    <= w_win;
         r_rr_ptr    <= w_win_next;
      end else if (w_slot_free) begin
         r_tlp_valid <= 1'b0;
      end
   end

   assign tlp_valid_o = r_tlp_valid;
   assign tlp_o       = r_tlp;
   assign tlp_vc_o    = r_tlp_vc;
   assign vc_empty_o  = w_empty;
   assign vc_full_o   = w_full;

endmodule

// File: tb/tb_pcie_tl_tx_mvc.sv
// Directed bench for pcie_tl_tx_mvc: 4 VCs, TCn->VC(n%4), two initial credits per VC.
// A cycle table covers latency, round-robin order and credit return; hand sequences cover the rest.
module tb_pcie_tl_tx_mvc;

   localparam int NUM_VC = 4;
   localparam int VC_W   = 2;
   localparam int HDR_W  = 96;
   localparam int DATA_W = 128;
   localparam int CRD_W  = 8;
   localparam int TLP_W  = HDR_W + DATA_W;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [8*VC_W-1:0]   tc2vc_map_i;
   logic                req_valid_i;
   logic                req_ready_o;
   logic [2:0]          req_tc_i;
   logic [HDR_W-1:0]    req_hdr_i;
   logic [DATA_W-1:0]   req_data_i;
   logic                crd_ret_valid_i;
   logic [VC_W-1:0]     crd_ret_vc_i;
   logic [CRD_W-1:0]    crd_ret_cnt_i;
   logic                tlp_valid_o;
   logic [TLP_W-1:0]    tlp_o;
   logic [VC_W-1:0]     tlp_vc_o;
   logic                tlp_ready_i;
   logic [NUM_VC-1:0]   vc_empty_o;
   logic [NUM_VC-1:0]   vc_full_o;

   always #5 clk = ~clk;

   pcie_tl_tx_mvc #(
      .NUM_VC     (NUM_VC),
      .HDR_W      (HDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (16),
      .CRD_W      (CRD_W),
      .INIT_CRD   (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tc2vc_map_i     (tc2vc_map_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_tc_i        (req_tc_i),
      .req_hdr_i       (req_hdr_i),
      .req_data_i      (req_data_i),
      .crd_ret_valid_i (crd_ret_valid_i),
      .crd_ret_vc_i    (crd_ret_vc_i),
      .crd_ret_cnt_i   (crd_ret_cnt_i),
      .tlp_valid_o     (tlp_valid_o),
      .tlp_o           (tlp_o),
      .tlp_vc_o        (tlp_vc_o),
      .tlp_ready_i     (tlp_ready_i),
      .vc_empty_o      (vc_empty_o),
      .vc_full_o       (vc_full_o)
   );

   typedef struct {
      logic       rst_n;
      logic       v;
      logic [2:0] tc;
      logic [7:0] tag;
      logic       tr;
      logic       cv;
      logic [1:0] cvc;
      logic [7:0] ccnt;
      logic       e_rdy;
      logic       e_val;
      logic [1:0] e_vc;
      logic [7:0] e_tag;
      logic [3:0] e_emp;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(input logic rst, input logic v, input logic [2:0] tc,
                               input logic [7:0] tag, input logic tr, input logic cv,
                               input logic [1:0] cvc, input logic [7:0] ccnt,
                               input logic e_rdy, input logic e_val, input logic [1:0] e_vc,
                               input logic [7:0] e_tag, input logic [3:0] e_emp);
      vec_t r;
      r.rst_n = rst;  r.v = v;        r.tc = tc;      r.tag = tag;   r.tr = tr;
      r.cv = cv;      r.cvc = cvc;    r.ccnt = ccnt;  r.e_rdy = e_rdy;
      r.e_val = e_val; r.e_vc = e_vc; r.e_tag = e_tag; r.e_emp = e_emp;
      return r;
   endfunction

   function automatic logic [HDR_W-1:0] mk_hdr(input logic [7:0] t);
      return {12{t}};
   endfunction

   function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] t);
      return {120'd0, t};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [2:0] tc, input logic [7:0] tag);
      req_valid_i = v;
      req_tc_i    = tc;
      req_hdr_i   = mk_hdr(tag);
      req_data_i  = mk_data(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_req(1'b0, 3'd0, 8'd0);
      crd_ret_valid_i = 1'b0;
      tlp_ready_i = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t r;
      int   n_acc, pushed, n_recv, dup, stab, n_out;
      logic pv, pr, pa;
      logic [TLP_W-1:0] pt;
      logic [VC_W-1:0]  pvc;
      logic [7:0]       mask;

      rst_n = 1'b0;
      tc2vc_map_i = 16'hE4E4;
      drive_req(1'b0, 3'd0, 8'd0);
      crd_ret_valid_i = 1'b0;
      crd_ret_vc_i = '0;
      crd_ret_cnt_i = '0;
      tlp_ready_i = 1'b0;
      repeat (3) tick();

      // Single TLP latency, credit exhaustion on VC0, VC1 unaffected.
      vecs.push_back(mk(0,0,0,8'h00,1,0,0,8'd0, 0,0,0,8'h00,4'hF));
      vecs.push_back(mk(1,1,0,8'hA5,1,0,0,8'd0, 1,0,0,8'h00,4'hE));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,0,8'hA5,4'hF));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hF));
      vecs.push_back(mk(1,1,0,8'h11,1,0,0,8'd0, 1,0,0,8'h00,4'hE));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,0,8'h11,4'hF));
      vecs.push_back(mk(1,1,0,8'h22,1,0,0,8'd0, 1,0,0,8'h00,4'hE));
      vecs.push_back(mk(1,1,1,8'h33,1,0,0,8'd0, 1,0,0,8'h00,4'hC));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,1,8'h33,4'hE));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hE));
      // Eight TCs back to back with output stalled, then released.
      vecs.push_back(mk(0,0,0,8'h00,1,0,0,8'd0, 0,0,0,8'h00,4'hF));
      vecs.push_back(mk(1,1,0,8'h10,0,0,0,8'd0, 1,0,0,8'h00,4'hE));
      vecs.push_back(mk(1,1,1,8'h11,0,0,0,8'd0, 1,1,0,8'h10,4'hD));
      vecs.push_back(mk(1,1,2,8'h12,0,0,0,8'd0, 1,1,0,8'h10,4'h9));
      vecs.push_back(mk(1,1,3,8'h13,0,0,0,8'd0, 1,1,0,8'h10,4'h1));
      vecs.push_back(mk(1,1,4,8'h14,0,0,0,8'd0, 1,1,0,8'h10,4'h0));
      vecs.push_back(mk(1,1,5,8'h15,0,0,0,8'd0, 1,1,0,8'h10,4'h0));
      vecs.push_back(mk(1,1,6,8'h16,0,0,0,8'd0, 1,1,0,8'h10,4'h0));
      vecs.push_back(mk(1,1,7,8'h17,0,0,0,8'd0, 1,1,0,8'h10,4'h0));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,1,8'h11,4'h0));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,2,8'h12,4'h0));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,3,8'h13,4'h0));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,0,8'h14,4'h1));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,1,8'h15,4'h3));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,2,8'h16,4'h7));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,3,8'h17,4'hF));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hF));
      // Three VC1 TLPs with two credits; one credit returned releases the third.
      vecs.push_back(mk(0,0,0,8'h00,1,0,0,8'd0, 0,0,0,8'h00,4'hF));
      vecs.push_back(mk(1,1,1,8'h31,1,0,0,8'd0, 1,0,0,8'h00,4'hD));
      vecs.push_back(mk(1,1,1,8'h32,1,0,0,8'd0, 1,1,1,8'h31,4'hD));
      vecs.push_back(mk(1,1,1,8'h33,1,0,0,8'd0, 1,1,1,8'h32,4'hD));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hD));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hD));
      vecs.push_back(mk(1,0,0,8'h00,1,1,1,8'd1, 1,0,0,8'h00,4'hD));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,1,1,8'h33,4'hF));
      vecs.push_back(mk(1,0,0,8'h00,1,0,0,8'd0, 1,0,0,8'h00,4'hF));

      for (int k = 0; k < vecs.size(); k++) begin
         r = vecs[k];
         rst_n = r.rst_n;
         drive_req(r.v, r.tc, r.tag);
         tlp_ready_i     = r.tr;
         crd_ret_valid_i = r.cv;
         crd_ret_vc_i    = r.cvc;
         crd_ret_cnt_i   = r.ccnt;
         #1;
         chk($sformatf("vec%0d.req_ready", k), req_ready_o, r.e_rdy);
         tick();
         chk($sformatf("vec%0d.tlp_valid", k), tlp_valid_o, r.e_val);
         chk($sformatf("vec%0d.vc_empty", k), vc_empty_o, r.e_emp);
         if (r.e_val) begin
            chk($sformatf("vec%0d.tlp_vc", k), tlp_vc_o, r.e_vc);
            chk($sformatf("vec%0d.tlp", k), tlp_o, {mk_hdr(r.e_tag), mk_data(r.e_tag)});
         end
         if (!r.rst_n) begin
            chk($sformatf("vec%0d.rst_full", k), vc_full_o, 4'h0);
            chk($sformatf("vec%0d.rst_tlp", k), tlp_o, '0);
            chk($sformatf("vec%0d.rst_vc", k), tlp_vc_o, 2'd0);
         end
         $display("vec %0d: valid=%0b vc=%0d tag=%0h empty=%0h", k, tlp_valid_o, tlp_vc_o,
                  tlp_o[7:0], vc_empty_o);
      end
      crd_ret_valid_i = 1'b0;

      // Fill VC0 with the output stalled; VC1 keeps accepting.
      do_reset();
      n_acc = 0;
      for (int i = 0; i < 40; i++) begin
         drive_req(1'b1, 3'd0, 8'(32'h40 + i));
         #1;
         if (!req_ready_o) break;
         n_acc++;
         tick();
      end
      chk("fill.accepted", n_acc, 17);
      chk("fill.full", vc_full_o, 4'h1);
      chk("fill.ready_vc0", req_ready_o, 1'b0);
      drive_req(1'b1, 3'd4, 8'h60);
      #1;
      chk("fill.ready_vc0_tc4", req_ready_o, 1'b0);
      drive_req(1'b1, 3'd1, 8'h60);
      #1;
      chk("fill.ready_vc1", req_ready_o, 1'b1);
      tick();
      drive_req(1'b0, 3'd0, 8'h00);
      chk("fill.empty", vc_empty_o, 4'hC);
      chk("fill.held_tlp", tlp_o, {mk_hdr(8'h40), mk_data(8'h40)});
      tlp_ready_i = 1'b1;
      tick();
      chk("fill.vc1_vc", tlp_vc_o, 2'd1);
      chk("fill.vc1_tlp", tlp_o, {mk_hdr(8'h60), mk_data(8'h60)});
      drive_req(1'b1, 3'd0, 8'h7F);
      #1;
      chk("fill.ready_full_pop", req_ready_o, 1'b0);
      tick();
      drive_req(1'b0, 3'd0, 8'h00);
      tlp_ready_i = 1'b0;
      chk("fill.full_after_pop", vc_full_o, 4'h0);
      chk("fill.pop_vc", tlp_vc_o, 2'd0);
      chk("fill.pop_tlp", tlp_o, {mk_hdr(8'h41), mk_data(8'h41)});
      $display("fill: accepted=%0d full=%0h", n_acc, vc_full_o);

      // Output ready toggling every cycle: hold stability, no loss or duplication.
      do_reset();
      pushed = 0; n_recv = 0; dup = 0; stab = 0; mask = '0;
      for (int c = 0; c < 60; c++) begin
         tlp_ready_i = c[0];
         drive_req(pushed < 8, 3'(pushed), 8'(32'h70 + pushed));
         #1;
         pv = tlp_valid_o; pr = tlp_ready_i; pt = tlp_o; pvc = tlp_vc_o;
         pa = req_valid_i & req_ready_o;
         tick();
         if (pa) pushed++;
         if (pv && pr) begin
            if (mask[pt[2:0]]) dup++;
            mask[pt[2:0]] = 1'b1;
            n_recv++;
            $display("toggle: tlp vc=%0d tag=%0h", pvc, pt[7:0]);
         end
         if (pv && !pr && (!tlp_valid_o || tlp_o !== pt || tlp_vc_o !== pvc)) stab++;
      end
      drive_req(1'b0, 3'd0, 8'h00);
      chk("toggle.received", n_recv, 8);
      chk("toggle.tags", mask, 8'hFF);
      chk("toggle.duplicates", dup, 0);
      chk("toggle.stability", stab, 0);

      // Credit saturation: 2 + 252 = 254, then consume 1 and return 5 together.
      do_reset();
      tlp_ready_i = 1'b1;
      crd_ret_valid_i = 1'b1; crd_ret_vc_i = 2'd2; crd_ret_cnt_i = 8'd252;
      tick();
      crd_ret_valid_i = 1'b0;
      drive_req(1'b1, 3'd2, 8'h80);
      tick();
      drive_req(1'b0, 3'd0, 8'h00);
      crd_ret_valid_i = 1'b1; crd_ret_vc_i = 2'd2; crd_ret_cnt_i = 8'd5;
      tick();
      crd_ret_valid_i = 1'b0;
      chk("sat.first_valid", tlp_valid_o, 1'b1);
      chk("sat.first_vc", tlp_vc_o, 2'd2);
      n_out = 0;
      for (int i = 0; i < 256; i++) begin
         drive_req(1'b1, 3'd2, 8'(i));
         tick();
         if (tlp_valid_o) n_out++;
      end
      drive_req(1'b0, 3'd0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tlp_valid_o) n_out++;
      end
      chk("sat.emitted", n_out, 255);
      chk("sat.leftover", vc_empty_o, 4'hB);
      $display("sat: emitted=%0d empty=%0h", n_out, vc_empty_o);

      // Reset with queued TLPs and a held output.
      do_reset();
      drive_req(1'b1, 3'd0, 8'h90); tick();
      drive_req(1'b1, 3'd1, 8'h91); tick();
      drive_req(1'b1, 3'd2, 8'h92); tick();
      drive_req(1'b0, 3'd0, 8'h00);
      chk("mrst.pre_valid", tlp_valid_o, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mrst.ready", req_ready_o, 1'b0);
      tick();
      chk("mrst.valid", tlp_valid_o, 1'b0);
      chk("mrst.tlp", tlp_o, '0);
      chk("mrst.vc", tlp_vc_o, 2'd0);
      chk("mrst.empty", vc_empty_o, 4'hF);
      chk("mrst.full", vc_full_o, 4'h0);
      rst_n = 1'b1;
      tlp_ready_i = 1'b1;
      n_out = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (tlp_valid_o) n_out++;
      end
      chk("mrst.discarded", n_out, 0);
      $display("mrst: post-reset outputs=%0d", n_out);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
